// File: rtl/serdes_pkg.sv
// Shared definitions for the FIR serial transmitter and receiver:
// FSM state encodings, default word length and counter sizing.
package serdes_pkg;

    localparam int LENGTH_DEF = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        LAST  = 3'b100
    } state_t;

    // Bit counter spans 0..LENGTH-1 with one bit of headroom.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/serializer_fsm_if.sv
// Parallel-in / serial-out handshake bundle between the FIR output,
// the serializer and the downstream bit consumer.
interface serializer_fsm_if
    import serdes_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF
);
    logic [LENGTH-1:0] iv_din;
    logic              i_din_valid;
    logic              o_ready;
    logic              o_dout;
    logic              o_dout_valid;
    logic              o_last;
    logic              i_ready;

    modport slave (
        input  iv_din, i_din_valid, i_ready,
        output o_ready, o_dout, o_dout_valid, o_last
    );

    modport master (
        output iv_din, i_din_valid, i_ready,
        input  o_ready, o_dout, o_dout_valid, o_last
    );
endinterface

// File: rtl/serializer_hold_reg.sv
// Single-entry holding buffer in front of the serializer shift register.
// o_ready is registered and reflects the buffer state after each edge.
module serializer_hold_reg
    import serdes_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_word,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_pop,
    output logic [LENGTH-1:0] ov_word,
    output logic              o_full
);
    logic [LENGTH-1:0] r_word;
    logic              r_full;
    logic              r_ready;
    logic              w_push;
    logic              w_full_nxt;

    // A push only happens while empty, so push and pop never coincide.
    assign w_push     = i_en && i_valid && r_ready;
    assign w_full_nxt = (r_full && !i_pop) || w_push;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word  <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b0;
        end else if (i_en) begin
            r_full  <= w_full_nxt;
            r_ready <= !w_full_nxt;
            if (w_push) begin
                r_word <= iv_word;
            end
        end
    end

    assign o_ready = r_ready;
    assign ov_word = r_word;
    assign o_full  = r_full;
endmodule

// File: rtl/serializer_fsm.sv
// LSB-first parallel-to-serial transmitter for the FIR output. A buffered
// word loads straight from LAST so consecutive words leave without a gap.
module serializer_fsm
    import serdes_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    serializer_fsm_if.slave bus
);
    localparam int CNT_W = cnt_width(LENGTH);

    state_t            r_state;
    logic [LENGTH-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_last;

    logic [LENGTH-1:0] w_buf;
    logic              w_full;
    logic              w_ready;
    logic              w_xfer;
    logic              w_pop;

    serializer_hold_reg #(.LENGTH(LENGTH)) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .iv_word (bus.iv_din),
        .i_valid (bus.i_din_valid),
        .o_ready (w_ready),
        .i_pop   (w_pop),
        .ov_word (w_buf),
        .o_full  (w_full)
    );

    assign w_xfer = i_en && r_dout_valid && bus.i_ready;
    assign w_pop  = i_en && w_full &&
                    ((r_state == IDLE) || ((r_state == LAST) && w_xfer));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
        end else if (i_en) begin
            if (w_pop) begin
                r_state      <= SHIFT;
                r_shift      <= w_buf;
                r_cnt        <= '0;
                r_dout       <= w_buf[0];
                r_dout_valid <= 1'b1;
                r_last       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    SHIFT: begin
                        if (w_xfer) begin
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_dout  <= r_shift[1];
                            // Bit LENGTH-2 just left; the final bit is now on o_dout.
                            if (r_cnt == CNT_W'(LENGTH - 2)) begin
                                r_state <= LAST;
                                r_last  <= 1'b1;
                            end
                        end
                    end
                    LAST: begin
                        if (w_xfer) begin
                            r_state      <= IDLE;
                            r_cnt        <= '0;
                            r_dout       <= 1'b0;
                            r_dout_valid <= 1'b0;
                            r_last       <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_cnt        <= '0;
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_last       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_dout       = r_dout;
    assign bus.o_dout_valid = r_dout_valid;
    assign bus.o_last       = r_last;
endmodule

// File: tb/tb_serializer_fsm.sv
// Directed bench for serializer_fsm: a reset/first-word vector table plus
// hand-written sequences for back-to-back, backpressure, full buffer, reset and enable.
module tb_serializer_fsm;
    import serdes_pkg::*;

    localparam int L = 24;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_en;

    serializer_fsm_if #(.LENGTH(L)) bus ();

    serializer_fsm #(.LENGTH(L)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          rst;
        bit          en;
        bit          dv;
        logic [23:0] din;
        bit          rdy;
        bit          e_ready;
        bit          e_dout;
        bit          e_dval;
        bit          e_last;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rx_bits[$];
    bit rx_last[$];
    int rx_edge[$];
    int cur_run, max_run;
    int stall_viol, en_viol;
    bit bp_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: record the transfer the coming edge performs, then sample after it.
    task automatic step();
        logic pd, pv, pl, pr;
        bit   stalled, frozen;
        if (bp_mode) bus.i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        pd = bus.o_dout; pv = bus.o_dout_valid; pl = bus.o_last; pr = bus.o_ready;
        if (i_en && !i_rst && pv === 1'b1 && bus.i_ready) begin
            rx_bits.push_back(pd);
            rx_last.push_back(pl);
            rx_edge.push_back(cyc);
        end
        stalled = i_en && !i_rst && pv === 1'b1 && !bus.i_ready;
        frozen  = !i_en && !i_rst;
        @(posedge i_clk);
        #1;
        cyc++;
        if (stalled && ({bus.o_dout, bus.o_dout_valid, bus.o_last} !== {pd, pv, pl})) stall_viol++;
        if (frozen && ({bus.o_dout, bus.o_dout_valid, bus.o_last, bus.o_ready} !== {pd, pv, pl, pr})) en_viol++;
        if (bus.o_dout_valid === 1'b1) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
    endtask

    task automatic send(input logic [23:0] w, input bit keep, output int acc_edge);
        bus.iv_din      = w;
        bus.i_din_valid = 1'b1;
        acc_edge        = -1;
        for (int k = 0; k < 200; k++) begin
            bit acc;
            int e;
            acc = i_en && !i_rst && (bus.o_ready === 1'b1);
            e   = cyc;
            step();
            if (acc) begin
                acc_edge = e;
                break;
            end
        end
        if (!keep) bus.i_din_valid = 1'b0;
        if (acc_edge < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send %0h: not accepted within 200 cycles", w);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        step();
        k = 0;
        while (bus.o_dout_valid === 1'b1 && k < 400) begin
            step();
            k++;
        end
        check({name, " back to idle"}, bus.o_dout_valid, 0);
    endtask

    function automatic logic [23:0] word_at(input int base, input bit use_last);
        logic [23:0] w;
        for (int k = 0; k < 24; k++) begin
            if (base + k < rx_bits.size()) w[k] = use_last ? rx_last[base + k] : rx_bits[base + k];
            else w[k] = 1'bx;
        end
        return w;
    endfunction

    task automatic clear_rx();
        rx_bits.delete();
        rx_last.delete();
        rx_edge.delete();
        cur_run    = 0;
        max_run    = 0;
        stall_viol = 0;
        en_viol    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   e1, e2, e3, n, k;

        i_rst = 1'b1; i_en = 1'b1;
        bus.iv_din = '0; bus.i_din_valid = 1'b0; bus.i_ready = 1'b1;
        clear_rx();

        // rst en dv din rdy | ready dout dval last  (0xA5C3F0 bits 0..4 = 0,0,0,0,1)
        tbl[0] = '{1, 1, 0, 24'h000000, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 24'hA5C3F0, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 24'h000000, 1, 1, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 24'hA5C3F0, 1, 1, 0, 0, 0};
        tbl[4] = '{0, 1, 1, 24'hA5C3F0, 1, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 24'h000000, 1, 1, 0, 1, 0};
        tbl[6] = '{0, 1, 0, 24'h000000, 1, 1, 0, 1, 0};
        tbl[7] = '{0, 1, 0, 24'h000000, 1, 1, 0, 1, 0};
        tbl[8] = '{0, 1, 0, 24'h000000, 1, 1, 0, 1, 0};
        tbl[9] = '{0, 1, 0, 24'h000000, 1, 1, 1, 1, 0};

        for (int i = 0; i < 10; i++) begin
            i_rst = tbl[i].rst; i_en = tbl[i].en;
            bus.i_din_valid = tbl[i].dv; bus.iv_din = tbl[i].din; bus.i_ready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d ready", i), bus.o_ready, tbl[i].e_ready);
            check($sformatf("vec%0d dout", i), bus.o_dout, tbl[i].e_dout);
            check($sformatf("vec%0d dout_valid", i), bus.o_dout_valid, tbl[i].e_dval);
            check($sformatf("vec%0d last", i), bus.o_last, tbl[i].e_last);
        end
        wait_idle("single");
        check("single bit count", rx_bits.size(), 24);
        check("single word", word_at(0, 0), 24'hA5C3F0);
        check("single last pos", word_at(0, 1), 24'h800000);
        check("single ready idle", bus.o_ready, 1);

        // Back-to-back words with the buffer kept full.
        clear_rx();
        send(24'hFFFFFF, 1, e1);
        send(24'h000001, 0, e2);
        check("b2b ready while buffered", bus.o_ready, 0);
        check("b2b accept spacing", e2 - e1, 2);
        wait_idle("b2b");
        check("b2b bit count", rx_bits.size(), 48);
        check("b2b word0", word_at(0, 0), 24'hFFFFFF);
        check("b2b word1", word_at(24, 0), 24'h000001);
        check("b2b last0", word_at(0, 1), 24'h800000);
        check("b2b last1", word_at(24, 1), 24'h800000);
        check("b2b valid run", max_run, 48);

        // Backpressure pattern 1,0,0,1.
        clear_rx();
        bp_mode = 1'b1;
        send(24'h800001, 0, e1);
        wait_idle("bp");
        bp_mode = 1'b0;
        bus.i_ready = 1'b1;
        check("bp bit count", rx_bits.size(), 24);
        check("bp word", word_at(0, 0), 24'h800001);
        check("bp last pos", word_at(0, 1), 24'h800000);
        check("bp stable while stalled", stall_viol, 0);

        // Third word offered while shift register and buffer are both occupied.
        clear_rx();
        send(24'h0F0F0F, 1, e1);
        send(24'h3C3C3C, 1, e2);
        send(24'h555555, 0, e3);
        wait_idle("full");
        check("full bit count", rx_bits.size(), 72);
        check("full word0", word_at(0, 0), 24'h0F0F0F);
        check("full word1", word_at(24, 0), 24'h3C3C3C);
        check("full word2", word_at(48, 0), 24'h555555);
        check("full accept after drain", e3, (rx_edge.size() > 23) ? rx_edge[23] + 1 : -1);

        // Reset mid-word with a second word waiting in the buffer.
        clear_rx();
        send(24'h123456, 1, e1);
        send(24'h654321, 0, e2);
        k = 0;
        while (rx_bits.size() < 10 && k < 100) begin step(); k++; end
        check("rst partial bits", rx_bits.size(), 10);
        i_rst = 1'b1;
        step();
        check("rst ready", bus.o_ready, 0);
        check("rst dout", bus.o_dout, 0);
        check("rst dout_valid", bus.o_dout_valid, 0);
        check("rst last", bus.o_last, 0);
        i_rst = 1'b0;
        step();
        check("rst release ready", bus.o_ready, 1);
        for (int i = 0; i < 3; i++) step();
        check("rst nothing emitted", rx_bits.size(), 10);
        check("rst stays idle", bus.o_dout_valid, 0);
        send(24'h00000F, 0, e1);
        wait_idle("rst");
        check("rst next count", rx_bits.size(), 34);
        check("rst next word", word_at(10, 0), 24'h00000F);
        check("rst next last", word_at(10, 1), 24'h800000);

        // Clock enable dropped for five cycles mid-word.
        clear_rx();
        send(24'h5A5A5A, 0, e1);
        k = 0;
        while (rx_bits.size() < 8 && k < 100) begin step(); k++; end
        i_en = 1'b0;
        n = rx_bits.size();
        for (int i = 0; i < 5; i++) step();
        check("en no transfers", rx_bits.size(), n);
        check("en outputs frozen", en_viol, 0);
        i_en = 1'b1;
        wait_idle("en");
        check("en bit count", rx_bits.size(), 24);
        check("en word", word_at(0, 0), 24'h5A5A5A);
        check("en last pos", word_at(0, 1), 24'h800000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
